// File: rtl/pkt_err_detector_p.sv
// Byte-serial packet monitor: frames on a two-symbol header, checks body length and
// checksum, and reports a sticky error cause plus saturating good/bad packet counts.
module pkt_err_detector_p #(
  parameter int                DATA_W     = 8,
  parameter int                BODY_LEN   = 8,
  parameter logic [DATA_W-1:0] HDR0       = 8'hBE,
  parameter logic [DATA_W-1:0] HDR1       = 8'hEF,
  parameter int                CKSUM_MODE = 0,
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data,
  output logic              error,
  output logic [3:0]        err_code,
  output logic              pkt_ok,
  output logic [CNT_W-1:0]  good_cnt,
  output logic [CNT_W-1:0]  bad_cnt
);

  localparam int CNT_BW = (BODY_LEN < 2) ? 1 : $clog2(BODY_LEN + 1);

  localparam logic [3:0] C_SHORT  = 4'b0001;
  localparam logic [3:0] C_LONG   = 4'b0010;
  localparam logic [3:0] C_CKSUM  = 4'b0100;
  localparam logic [3:0] C_HEADER = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_H0,
    S_BODY,
    S_CK,
    S_TAIL
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [DATA_W-1:0] cksum_next(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] d);
    if (CKSUM_MODE == 1) return a ^ d;
    else                 return a + d;
  endfunction

  state_t              state, state_n;
  logic [DATA_W-1:0]   acc, acc_n;
  logic [CNT_BW-1:0]   cnt, cnt_n;
  logic                pkt_err, pkt_err_n;
  logic                first_body, first_body_n;
  logic                pkt_seen, pkt_seen_n;
  logic                error_n;
  logic [3:0]          err_code_n;
  logic                pkt_ok_n;
  logic [CNT_W-1:0]    good_cnt_n, bad_cnt_n;
  logic [3:0]          cause;
  logic                clear_base;
  logic                base_err;
  logic [3:0]          base_code;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      acc        <= '0;
      cnt        <= '0;
      pkt_err    <= 1'b0;
      first_body <= 1'b0;
      pkt_seen   <= 1'b0;
      error      <= 1'b0;
      err_code   <= 4'b0;
      pkt_ok     <= 1'b0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      cnt        <= cnt_n;
      pkt_err    <= pkt_err_n;
      first_body <= first_body_n;
      pkt_seen   <= pkt_seen_n;
      error      <= error_n;
      err_code   <= err_code_n;
      pkt_ok     <= pkt_ok_n;
      good_cnt   <= good_cnt_n;
      bad_cnt    <= bad_cnt_n;
    end
  end

  always_comb begin
    state_n      = state;
    acc_n        = acc;
    cnt_n        = cnt;
    pkt_err_n    = pkt_err;
    first_body_n = first_body;
    pkt_seen_n   = pkt_seen;
    good_cnt_n   = good_cnt;
    bad_cnt_n    = bad_cnt;
    pkt_ok_n     = 1'b0;
    cause        = 4'b0;
    clear_base   = 1'b0;

    if (data_valid) begin
      unique case (state)
        S_IDLE: begin
          if (data == HDR0) state_n = S_H0;
        end
        S_H0: begin
          if (data == HDR1) begin
            state_n      = S_BODY;
            cnt_n        = '0;
            acc_n        = '0;
            pkt_err_n    = 1'b0;
            first_body_n = 1'b1;
            pkt_seen_n   = 1'b1;
          end else if (data != HDR0) begin
            cause   = C_HEADER;
            state_n = pkt_seen ? S_TAIL : S_IDLE;
          end
        end
        S_BODY: begin
          // The first body symbol of a packet wipes the previous packet's report.
          clear_base   = first_body;
          first_body_n = 1'b0;
          if (data == HDR0) begin
            cause   = C_SHORT;
            state_n = S_H0;
          end else if (data == HDR1) begin
            cause = C_HEADER;
          end else begin
            acc_n = cksum_next(acc, data);
            cnt_n = cnt + 1'b1;
            if (cnt_n == CNT_BW'(BODY_LEN)) state_n = S_CK;
          end
        end
        S_CK: begin
          if (data == HDR0) begin
            cause   = C_SHORT;
            state_n = S_H0;
          end else if (data == HDR1) begin
            cause = C_HEADER;
          end else begin
            if (data == acc) begin
              pkt_ok_n   = 1'b1;
              good_cnt_n = sat_inc(good_cnt);
            end else begin
              cause = C_CKSUM;
            end
            state_n = S_TAIL;
          end
        end
        S_TAIL: begin
          if (data == HDR0) state_n = S_H0;
          else              cause   = C_LONG;
        end
        default: state_n = S_IDLE;
      endcase
    end

    base_err   = clear_base ? 1'b0 : error;
    base_code  = clear_base ? 4'b0 : err_code;
    error_n    = base_err | (|cause);
    err_code_n = base_code | cause;

    // Only the first fault of a packet counts towards bad_cnt.
    if (|cause) begin
      pkt_err_n = 1'b1;
      if (!pkt_err) bad_cnt_n = sat_inc(bad_cnt);
    end
  end

endmodule

// File: doc/pkt_err_detector_p.md
Name: pkt_err_detector_p

Overview:
- Parametrised packet error detector for a byte-serial stream with a valid qualifier.
- Frames packets on a 2-symbol header, then checks body length and checksum.
- Reports errors through a sticky error flag, a cause code, and saturating good/bad packet counters.
- Used as a stream monitor ahead of packet consumers; purely observing, no backpressure.

Parameters:
DATA_W, 8, symbol width in bits
BODY_LEN, 8, body symbols per packet (>=1); total packet = BODY_LEN+3 symbols
HDR0, 8'hBE, first header symbol (DATA_W wide)
HDR1, 8'hEF, second header symbol (DATA_W wide)
CKSUM_MODE, 0, 0 = sum of body mod 2^DATA_W; 1 = XOR of body
CNT_W, 16, width of packet counters

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
data_valid  input  1  data is a stream symbol this cycle
data  input  DATA_W  stream symbol
error  output  1  packet error flag, registered
err_code  output  4  sticky cause: [0] short, [1] long, [2] checksum, [3] header
pkt_ok  output  1  one-cycle pulse: checksum matched at correct position
good_cnt  output  CNT_W  packets with pkt_ok, saturating
bad_cnt  output  CNT_W  packets flagged erroneous, saturating

Behaviour:
- Reset (reset=0, async): state IDLE; error=0, err_code=0, pkt_ok=0, counters=0, accumulator=0, body count=0.
- Only edges with data_valid=1 act; data_valid=0 holds all state. pkt_ok is still cleared to 0 on such edges.
- All outputs registered: the effect of a symbol appears in the cycle after its accepting edge.
- States:
  - IDLE: no header seen since reset. Non-HDR0 symbols are ignored, no error. HDR0 -> H0.
  - H0: HDR1 -> BODY, clearing count and accumulator. HDR0 -> stay H0. Other symbol -> header error, then -> TAIL if a packet preceded, else IDLE.
  - BODY: a symbol that is not HDR0/HDR1 is accumulated and the count incremented. When count reaches BODY_LEN -> CK.
  - CK: the symbol is compared with the accumulator.
    - Match -> pkt_ok=1 for one cycle, good_cnt+1.
    - Mismatch -> checksum error.
    - Either way -> TAIL.
  - TAIL: awaiting the next header. HDR0 -> H0. Any other symbol -> long error (flagged once per packet), stay TAIL.
- Accumulator:
  - CKSUM_MODE=0: acc <= acc + data, truncated to DATA_W bits (wrap mod 2^DATA_W).
  - CKSUM_MODE=1: acc <= acc ^ data.
- HDR0 received in BODY or CK -> short error, -> H0.
- HDR1 received in BODY or CK -> header error; symbol not accumulated and not counted; state unchanged.
- Error set: on the accepting edge of the offending symbol.
  - error <= 1; err_code bit ORed in.
  - bad_cnt increments only on the first error of the current packet (per-packet flag, cleared on HDR1 acceptance in H0).
- Error clear: on the edge accepting Byte 2 (first body symbol) of the next packet, error<=0 and err_code<=0.
  - If that same symbol is itself erroneous (HDR1), the new error wins: error stays 1 and err_code = the new cause only.
- Several errors before clearing: err_code accumulates (OR). error stays 1.
- Counters saturate at 2^CNT_W-1.
- Reset mid-packet: immediate return to IDLE; the partial packet is not counted.

Test Plan:
- BODY_LEN=8, mode 0: BE EF 01 02 03 04 05 06 07 08 24 -> pkt_ok pulse the cycle after 24; error=0; good_cnt=1; bad_cnt=0.
- Same packet with checksum 25, then BE EF 11... -> error=1, err_code=4'b0100 from the cycle after 25 until the cycle after 11, then 0; bad_cnt=1.
- Short: BE EF 01 02 03 BE EF 01..08 24 -> error=1, err_code=4'b0001 after the second BE; cleared after the following 01; then pkt_ok; good_cnt=1, bad_cnt=1.
- Long: good packet, then 55 66, then BE EF 01.. -> error=1, err_code=4'b0010 after 55; bad_cnt increments once only (66 adds nothing); cleared after 01.
- CKSUM_MODE=1: BE EF 01..08 08 with random data_valid=0 gaps -> pkt_ok, no error; gaps change nothing.
- Reset low mid-body, then release and send a good packet -> all outputs 0 during reset; after release, good_cnt=1, bad_cnt=0.
